// File: rtl/xbus_arbiter.sv
// xbus_arbiter: two-master round-robin arbiter and request mux for the xbus.
// Registered grants, combinational address strobe, shared read data.
// Optional hold-limit preemption is compiled in with XBUS_ARB_HOLD_LIMIT_EN.
module xbus_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    output logic        m0_gnt,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    output logic        m1_gnt,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        xbus_as,
    output logic        xbus_we,
    output logic [3:0]  xbus_be,
    output logic [31:0] xbus_addr,
    output logic [31:0] xbus_wdata,
    input  logic [31:0] xbus_rdata
);

`ifdef XBUS_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_last;
    logic       w_last_nxt;
    logic [7:0] r_hold_cnt;
    logic [7:0] w_hold_nxt;
    logic       w_other_req;
    logic       w_hold_expired;

    // State register: owner, last owner and contention counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_hold_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Next-state logic: round-robin from IDLE, handover on release, optional preemption.
    // hold_cnt counts cycles the owner has kept the bus while the other master waits.
    always_comb begin
        w_state_nxt    = r_state;
        w_last_nxt     = r_last;
        w_hold_nxt     = 8'd0;
        w_other_req    = (r_state == S_OWN0) ? m1_req : m0_req;
        w_hold_expired = HOLD_EN && (r_hold_cnt == HOLD_LAST);
        case (r_state)
            S_IDLE: begin
                if (m0_req && m1_req) w_state_nxt = r_last ? S_OWN0 : S_OWN1;
                else if (m0_req)      w_state_nxt = S_OWN0;
                else if (m1_req)      w_state_nxt = S_OWN1;
            end
            S_OWN0: begin
                if (!m0_req)                      w_state_nxt = m1_req ? S_OWN1 : S_IDLE;
                else if (m1_req && w_hold_expired) w_state_nxt = S_OWN1;
            end
            S_OWN1: begin
                if (!m1_req)                      w_state_nxt = m0_req ? S_OWN0 : S_IDLE;
                else if (m0_req && w_hold_expired) w_state_nxt = S_OWN0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_state_nxt != r_state) begin
            if (w_state_nxt == S_OWN0) w_last_nxt = 1'b0;
            if (w_state_nxt == S_OWN1) w_last_nxt = 1'b1;
        end else if (r_state != S_IDLE && w_other_req) begin
            w_hold_nxt = (r_hold_cnt == 8'hFF) ? r_hold_cnt : r_hold_cnt + 8'd1;
        end
    end

    // Output logic: grant decode, gated strobe and owner field mux.
    always_comb begin
        m0_gnt     = (r_state == S_OWN0);
        m1_gnt     = (r_state == S_OWN1);
        xbus_as    = 1'b0;
        xbus_we    = 1'b0;
        xbus_be    = 4'd0;
        xbus_addr  = 32'd0;
        xbus_wdata = 32'd0;
        if (r_state == S_OWN0) begin
            xbus_as    = !rst && m0_req;
            xbus_we    = m0_we;
            xbus_be    = m0_be;
            xbus_addr  = m0_addr;
            xbus_wdata = m0_wdata;
        end else if (r_state == S_OWN1) begin
            xbus_as    = !rst && m1_req;
            xbus_we    = m1_we;
            xbus_be    = m1_be;
            xbus_addr  = m1_addr;
            xbus_wdata = m1_wdata;
        end
    end

    // Read data is broadcast; masters qualify it with their own grant.
    assign m0_rdata = xbus_rdata;
    assign m1_rdata = xbus_rdata;

endmodule

// File: tb/tb_xbus_arbiter.sv
// tb_xbus_arbiter: directed + random stimulus, reference model and scoreboard.
module tb_xbus_arbiter;

    localparam int unsigned MAX_HOLD = 4;
`ifdef XBUS_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_gnt, m1_gnt;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [3:0]  m0_be = 4'd0, m1_be = 4'd0;
    logic [31:0] m0_addr = 32'd0, m1_addr = 32'd0;
    logic [31:0] m0_wdata = 32'd0, m1_wdata = 32'd0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        xbus_as, xbus_we;
    logic [3:0]  xbus_be;
    logic [31:0] xbus_addr, xbus_wdata;
    logic [31:0] xbus_rdata = 32'd0;

    always #5 clk = ~clk;

    xbus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_we(m0_we), .m0_be(m0_be),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_we(m1_we), .m1_be(m1_be),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .xbus_as(xbus_as), .xbus_we(xbus_we), .xbus_be(xbus_be),
        .xbus_addr(xbus_addr), .xbus_wdata(xbus_wdata), .xbus_rdata(xbus_rdata)
    );

    typedef struct packed {
        logic        gnt0;
        logic        gnt1;
        logic        as_;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: who owns the bus, who owned it last, how long the waiter has waited.
    int mdl_owner = -1;
    int mdl_last  = 1;
    int mdl_wait  = 0;
    bit mdl_known = 1'b0;
    bit p_rst = 1'b1;
    bit p_r0  = 1'b0;
    bit p_r1  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // Advance the model by one clock edge using the inputs held during the previous cycle.
    task automatic model_step();
        int nxt;
        bit mine;
        bit other;
        nxt = mdl_owner;
        if (p_rst) begin
            mdl_owner = -1;
            mdl_last  = 1;
            mdl_wait  = 0;
            mdl_known = 1'b1;
        end else if (mdl_known) begin
            if (mdl_owner < 0) begin
                if (p_r0 && p_r1) nxt = 1 - mdl_last;
                else if (p_r0)    nxt = 0;
                else if (p_r1)    nxt = 1;
            end else begin
                mine  = (mdl_owner == 0) ? p_r0 : p_r1;
                other = (mdl_owner == 0) ? p_r1 : p_r0;
                if (!mine) nxt = other ? 1 - mdl_owner : -1;
                else if (HOLD_EN && other && mdl_wait == int'(MAX_HOLD) - 1) nxt = 1 - mdl_owner;
                if (nxt == mdl_owner) mdl_wait = other ? ((mdl_wait < 255) ? mdl_wait + 1 : 255) : 0;
            end
            if (nxt >= 0 && nxt != mdl_owner) begin
                mdl_last = nxt;
                mdl_wait = 0;
            end
            mdl_owner = nxt;
        end
    endtask

    // One cycle of stimulus: update model, drive inputs, queue the expected response.
    task automatic drive(input bit rst_v, input bit r0, input bit r1,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] rd);
        exp_t e;
        @(posedge clk);
        #1;
        model_step();
        rst        = rst_v;
        m0_req     = r0;
        m1_req     = r1;
        m0_addr    = a0;
        m1_addr    = a1;
        m0_we      = 1'($urandom);
        m1_we      = 1'($urandom);
        m0_be      = 4'($urandom);
        m1_be      = 4'($urandom);
        m0_wdata   = $urandom;
        m1_wdata   = $urandom;
        xbus_rdata = rd;
        p_rst = rst_v;
        p_r0  = r0;
        p_r1  = r1;
        if (mdl_known) begin
            e = '0;
            e.gnt0 = (mdl_owner == 0);
            e.gnt1 = (mdl_owner == 1);
            e.rd0  = rd;
            e.rd1  = rd;
            if (mdl_owner == 0) begin
                e.as_ = !rst_v && r0;
                e.we = m0_we; e.be = m0_be; e.addr = a0; e.wdata = m0_wdata;
            end else if (mdl_owner == 1) begin
                e.as_ = !rst_v && r1;
                e.we = m1_we; e.be = m1_be; e.addr = a1; e.wdata = m1_wdata;
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, $urandom, $urandom, $urandom);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("m0_gnt",     32'(m0_gnt),  32'(e.gnt0));
                chk("m1_gnt",     32'(m1_gnt),  32'(e.gnt1));
                chk("xbus_as",    32'(xbus_as), 32'(e.as_));
                chk("xbus_we",    32'(xbus_we), 32'(e.we));
                chk("xbus_be",    32'(xbus_be), 32'(e.be));
                chk("xbus_addr",  xbus_addr,    e.addr);
                chk("xbus_wdata", xbus_wdata,   e.wdata);
                chk("m0_rdata",   m0_rdata,     e.rd0);
                chk("m1_rdata",   m1_rdata,     e.rd1);
            end
        end
    end

    initial begin
        bit r0;
        bit r1;
        bit rs;
        // Reset with both masters requesting, then m0 wins the first tie.
        drive(1'b1, 1'b1, 1'b1, 32'h40, 32'h100, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 32'h40, 32'h100, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h100, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h100, 32'h0);
        idle_cycles(2);
        // Single m1 request, released after two strobes, with a read on the bus.
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h100, 32'h0);
        idle_cycles(2);
        // Round-robin: m0 alone, then ties from IDLE alternate.
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h100, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h100, 32'h0);
        idle_cycles(2);
        drive(1'b0, 1'b1, 1'b1, 32'h44, 32'h104, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h44, 32'h104, 32'h0);
        idle_cycles(2);
        drive(1'b0, 1'b1, 1'b1, 32'h48, 32'h108, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h48, 32'h108, 32'h0);
        idle_cycles(2);
        // Contention: m0 owns, m1 requests and keeps requesting for 20 cycles.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 32'h50, 32'h200, 32'h0);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'b1, 32'h50, 32'h200, $urandom);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 32'h50, 32'h200, $urandom);
        // Reset in the middle of an m1 grant.
        drive(1'b1, 1'b0, 1'b1, 32'h50, 32'h200, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h50, 32'h200, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h50, 32'h200, 32'h0);
        idle_cycles(2);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            rs = ($urandom_range(0, 63) == 0);
            drive(rs, r0, r1, $urandom, $urandom, $urandom);
        end
        idle_cycles(2);
        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
